// File: rtl/sw_debounce.sv
// sw_debounce: synchronises and debounces N_SW slide-switch inputs.
// Each bit passes through a two-flop synchroniser, then a per-bit FSM that
// accepts a new level only after DEBOUNCE_CYCLES consecutive equal samples.
//
// Ports:
//   clk       in   1     system clock
//   rst       in   1     synchronous, active-high reset
//   sw_in     in   N_SW  raw asynchronous switch inputs
//   sw_level  out  N_SW  debounced switch levels
//   sw_rise   out  N_SW  one-cycle pulse on an accepted 0->1 change
//   sw_fall   out  N_SW  one-cycle pulse on an accepted 1->0 change
//   sw_toggle out  N_SW  (SW_DEBOUNCE_TOGGLE_EN only) inverts on each sw_rise
//   led_out   out  1     |sw_level, or |sw_toggle with SW_DEBOUNCE_TOGGLE_EN
//
// Optional feature macro: SW_DEBOUNCE_TOGGLE_EN
module sw_debounce #(
   parameter int unsigned N_SW            = 3,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned CNT_W           = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_SW-1:0] sw_in,
   output logic [N_SW-1:0] sw_level,
   output logic [N_SW-1:0] sw_rise,
   output logic [N_SW-1:0] sw_fall,
`ifdef SW_DEBOUNCE_TOGGLE_EN
   output logic [N_SW-1:0] sw_toggle,
`endif
   output logic            led_out
);

   typedef enum logic [1:0] {S0, W1, S1, W0} state_e;

   // Count value reached on the edge that registers the last qualifying sample
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_SW-1:0]  sync1_q, sync1_d;
   logic [N_SW-1:0]  sync2_q, sync2_d;
   state_e           state_q [N_SW];
   state_e           state_d [N_SW];
   logic [CNT_W-1:0] cnt_q   [N_SW];
   logic [CNT_W-1:0] cnt_d   [N_SW];
   logic [N_SW-1:0]  level_q, level_d;
   logic [N_SW-1:0]  rise_q, rise_d;
   logic [N_SW-1:0]  fall_q, fall_d;
   logic             led_q, led_d;
`ifdef SW_DEBOUNCE_TOGGLE_EN
   logic [N_SW-1:0]  tog_q, tog_d;
`endif

   // Synchroniser, per-bit debounce FSMs and output derivation
   always_comb begin
      sync1_d = sw_in;
      sync2_d = sync1_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = '0;
      fall_d  = '0;

      for (int i = 0; i < int'(N_SW); i++) begin
         case (state_q[i])
            S0: begin
               if (sync2_q[i]) begin
                  state_d[i] = W1;
                  cnt_d[i]   = CNT_W'(1);
               end
            end
            W1: begin
               if (!sync2_q[i]) begin
                  state_d[i] = S0;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CNT_LAST) begin
                  state_d[i] = S1;
                  cnt_d[i]   = '0;
                  level_d[i] = 1'b1;
                  rise_d[i]  = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            S1: begin
               if (!sync2_q[i]) begin
                  state_d[i] = W0;
                  cnt_d[i]   = CNT_W'(1);
               end
            end
            W0: begin
               if (sync2_q[i]) begin
                  state_d[i] = S1;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CNT_LAST) begin
                  state_d[i] = S0;
                  cnt_d[i]   = '0;
                  level_d[i] = 1'b0;
                  fall_d[i]  = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            default: begin
               state_d[i] = S0;
               cnt_d[i]   = '0;
            end
         endcase
      end

`ifdef SW_DEBOUNCE_TOGGLE_EN
      // Toggle flips with the rise pulse; led follows one edge later
      tog_d = tog_q ^ rise_d;
      led_d = |tog_q;
`else
      // Computed from the next level so led changes on the same edge
      led_d = |level_d;
`endif
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         state_q <= '{default: S0};
         cnt_q   <= '{default: '0};
         level_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         led_q   <= 1'b0;
`ifdef SW_DEBOUNCE_TOGGLE_EN
         tog_q   <= '0;
`endif
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         led_q   <= led_d;
`ifdef SW_DEBOUNCE_TOGGLE_EN
         tog_q   <= tog_d;
`endif
      end
   end

   assign sw_level  = level_q;
   assign sw_rise   = rise_q;
   assign sw_fall   = fall_q;
   assign led_out   = led_q;
`ifdef SW_DEBOUNCE_TOGGLE_EN
   assign sw_toggle = tog_q;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed bench for sw_debounce (N_SW=3, DEBOUNCE_CYCLES=4).
// A window-based reference model (accept when the last D synchronised
// samples all disagree with the current level) is compared every cycle,
// and literal expectations pin both the DUT and the model at key edges.
module tb_sw_debounce;

   localparam int N = 3;
   localparam int D = 4;

   logic         clk;
   logic         rst;
   logic [N-1:0] sw_in;
   logic [N-1:0] sw_level;
   logic [N-1:0] sw_rise;
   logic [N-1:0] sw_fall;
   logic         led_out;
`ifdef SW_DEBOUNCE_TOGGLE_EN
   logic [N-1:0] sw_toggle;
`endif

   int total = 0;
   int bad   = 0;

   sw_debounce #(
      .N_SW           (N),
      .DEBOUNCE_CYCLES(D),
      .CNT_W          (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .sw_in    (sw_in),
      .sw_level (sw_level),
      .sw_rise  (sw_rise),
      .sw_fall  (sw_fall),
`ifdef SW_DEBOUNCE_TOGGLE_EN
      .sw_toggle(sw_toggle),
`endif
      .led_out  (led_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [N-1:0] p1, p2, s_m;
   logic [N-1:0] m_level, m_rise, m_fall, m_tog;
   logic         m_led;
   logic [D-1:0] win [N];
   bit           model_valid = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
      end
   endtask

   // Literal expectation applied to both DUT and model
   task automatic lit(input string name, input logic [31:0] got, input logic [31:0] mdl,
                      input logic [31:0] want);
      check(name, got, want);
      check({name, "_model"}, mdl, want);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Model: a level flips once the last D synchronised samples all differ from it
   always @(posedge clk) begin
      if (rst) begin
         p1 = '0; p2 = '0;
         m_level = '0; m_rise = '0; m_fall = '0; m_tog = '0; m_led = 1'b0;
         for (int i = 0; i < N; i++) win[i] = '0;
      end else begin
         s_m = p2;
         p2  = p1;
         p1  = sw_in;
         m_rise = '0;
         m_fall = '0;
         for (int i = 0; i < N; i++) begin
            win[i] = {win[i][D-2:0], s_m[i]};
            if (win[i] == {D{~m_level[i]}}) begin
               m_level[i] = ~m_level[i];
               if (m_level[i]) m_rise[i] = 1'b1;
               else            m_fall[i] = 1'b1;
            end
         end
`ifdef SW_DEBOUNCE_TOGGLE_EN
         m_led = |m_tog;
         m_tog = m_tog ^ m_rise;
`else
         m_led = |m_level;
`endif
      end
      model_valid = 1'b1;
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (model_valid) begin
         check("cyc_level", 32'(sw_level), 32'(m_level));
         check("cyc_rise",  32'(sw_rise),  32'(m_rise));
         check("cyc_fall",  32'(sw_fall),  32'(m_fall));
         check("cyc_led",   32'(led_out),  32'(m_led));
         check("cyc_rise_and_fall", 32'(sw_rise & sw_fall), 32'd0);
`ifdef SW_DEBOUNCE_TOGGLE_EN
         check("cyc_toggle", 32'(sw_toggle), 32'(m_tog));
`endif
      end
   end

   initial begin
      rst   = 1'b1;
      sw_in = 3'b111;

      // 1: reset held with all inputs high
      for (int k = 0; k < 3; k++) begin
         tick(1);
         lit("rst_level", 32'(sw_level), 32'(m_level), 32'd0);
         lit("rst_pulses", 32'(sw_rise | sw_fall), 32'(m_rise | m_fall), 32'd0);
         lit("rst_led", 32'(led_out), 32'(m_led), 32'd0);
      end
      rst   = 1'b0;
      sw_in = 3'b000;
      tick(1);
      lit("post_rst_rise", 32'(sw_rise), 32'(m_rise), 32'd0);
      lit("post_rst_fall", 32'(sw_fall), 32'(m_fall), 32'd0);

      // 4: three-cycle pulse on bit 2 is rejected
      sw_in = 3'b100;
      tick(3);
      sw_in = 3'b000;
      tick(8);
      lit("short_level", 32'(sw_level), 32'(m_level), 32'd0);
      lit("short_led", 32'(led_out), 32'(m_led), 32'd0);

      // 2: clean step on bit 0, accepted D+2 edges later
      sw_in = 3'b001;
      tick(5);
      lit("step_early", 32'(sw_level), 32'(m_level), 32'd0);
      tick(1);
      lit("step_level", 32'(sw_level), 32'(m_level), 32'h1);
      lit("step_rise", 32'(sw_rise), 32'(m_rise), 32'h1);
`ifndef SW_DEBOUNCE_TOGGLE_EN
      lit("step_led", 32'(led_out), 32'(m_led), 32'd1);
`endif
      tick(1);
      lit("step_rise_end", 32'(sw_rise), 32'(m_rise), 32'd0);

      // 3: bounce on bit 1, then hold
      sw_in = 3'b011; tick(1);
      sw_in = 3'b001; tick(1);
      sw_in = 3'b011; tick(1);
      sw_in = 3'b001; tick(1);
      lit("bounce_level", 32'(sw_level), 32'(m_level), 32'h1);
      sw_in = 3'b011;
      tick(5);
      lit("bounce_early", 32'(sw_level), 32'(m_level), 32'h1);
      tick(1);
      lit("bounce_level_ok", 32'(sw_level), 32'(m_level), 32'h3);
      lit("bounce_rise", 32'(sw_rise), 32'(m_rise), 32'h2);
      tick(1);
      lit("bounce_rise_end", 32'(sw_rise), 32'(m_rise), 32'd0);

      // 5: all bits high, then simultaneous release
      sw_in = 3'b111;
      tick(6);
      lit("all_high", 32'(sw_level), 32'(m_level), 32'h7);
      lit("all_high_rise", 32'(sw_rise), 32'(m_rise), 32'h4);
      tick(4);
      sw_in = 3'b000;
      tick(5);
      lit("release_early", 32'(sw_level), 32'(m_level), 32'h7);
      tick(1);
      lit("release_level", 32'(sw_level), 32'(m_level), 32'd0);
      lit("release_fall", 32'(sw_fall), 32'(m_fall), 32'h7);
`ifndef SW_DEBOUNCE_TOGGLE_EN
      lit("release_led", 32'(led_out), 32'(m_led), 32'd0);
`endif
      tick(1);
      lit("release_fall_end", 32'(sw_fall), 32'(m_fall), 32'd0);

      // 6: reset mid-qualification restarts the full latency
      sw_in = 3'b001;
      tick(4);
      rst = 1'b1;
      tick(1);
      lit("midrst_level", 32'(sw_level), 32'(m_level), 32'd0);
      rst = 1'b0;
      tick(5);
      lit("midrst_early", 32'(sw_level), 32'(m_level), 32'd0);
      tick(1);
      lit("midrst_level_ok", 32'(sw_level), 32'(m_level), 32'h1);
      lit("midrst_rise", 32'(sw_rise), 32'(m_rise), 32'h1);

`ifdef SW_DEBOUNCE_TOGGLE_EN
      lit("toggle_first", 32'(sw_toggle), 32'(m_tog), 32'h1);
      sw_in = 3'b000;
      tick(7);
      sw_in = 3'b001;
      tick(6);
      lit("toggle_second", 32'(sw_toggle), 32'(m_tog), 32'd0);
`endif

      tick(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
